// File: rtl/sdram_burst_write.sv
// Full-page SDRAM write burst: ACTIVE, WRITE plus streamed beats, BURST_STOP,
// PRECHARGE all, then a one-cycle wr_end back to the arbiter.
module sdram_burst_write #(
  parameter int TRCD_CLK = 2,
  parameter int TRP_CLK  = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        wr_en,
  input  logic [22:0] wr_addr,
  input  logic [9:0]  wr_burst_len,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        wr_end,
  output logic [3:0]  wr_cmd,
  output logic [1:0]  wr_ba,
  output logic [12:0] wr_sdram_addr,
  output logic        wr_sdram_en,
  output logic [15:0] wr_sdram_data
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ACTIVE = 4'd1;
  localparam logic [3:0] S_TRCD   = 4'd2;
  localparam logic [3:0] S_WRITE  = 4'd3;
  localparam logic [3:0] S_DATA   = 4'd4;
  localparam logic [3:0] S_STOP   = 4'd5;
  localparam logic [3:0] S_PRECH  = 4'd6;
  localparam logic [3:0] S_TRP    = 4'd7;
  localparam logic [3:0] S_END    = 4'd8;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_BSTOP     = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

  // Last counter value of the NOP wait states (only reached when the wait exists)
  localparam logic [9:0] TRCD_LAST = 10'((TRCD_CLK > 1) ? TRCD_CLK - 2 : 0);
  localparam logic [9:0] TRP_LAST  = 10'((TRP_CLK > 1) ? TRP_CLK - 2 : 0);

  logic [3:0] state_reg, state_next;
  logic [9:0] cnt_reg, cnt_next;
  logic [1:0] bank_reg;
  logic [7:0] col_reg;
  logic [9:0] len_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE:   if (wr_en && init_end) state_next = S_ACTIVE;
      S_ACTIVE: begin
        cnt_next   = 10'd0;
        state_next = (TRCD_CLK > 1) ? S_TRCD : S_WRITE;
      end
      S_TRCD: begin
        if (cnt_reg == TRCD_LAST) begin
          cnt_next   = 10'd0;
          state_next = S_WRITE;
        end else begin
          cnt_next = cnt_reg + 10'd1;
        end
      end
      S_WRITE: begin
        // cnt holds the index of the beat carried in the current DATA cycle
        cnt_next   = 10'd1;
        state_next = (len_reg == 10'd1) ? S_STOP : S_DATA;
      end
      S_DATA: begin
        if (cnt_reg == len_reg - 10'd1) begin
          cnt_next   = 10'd0;
          state_next = S_STOP;
        end else begin
          cnt_next = cnt_reg + 10'd1;
        end
      end
      S_STOP:  state_next = S_PRECH;
      S_PRECH: begin
        cnt_next   = 10'd0;
        state_next = (TRP_CLK > 1) ? S_TRP : S_END;
      end
      S_TRP: begin
        if (cnt_reg == TRP_LAST) begin
          cnt_next   = 10'd0;
          state_next = S_END;
        end else begin
          cnt_next = cnt_reg + 10'd1;
        end
      end
      S_END:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the
  // same cycle as the state they belong to.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 10'd0;
      bank_reg      <= 2'd0;
      col_reg       <= 8'd0;
      len_reg       <= 10'd0;
      wr_cmd        <= CMD_NOP;
      wr_ba         <= 2'd0;
      wr_sdram_addr <= 13'd0;
      wr_sdram_en   <= 1'b0;
      wr_ack        <= 1'b0;
      wr_end        <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == S_IDLE && state_next == S_ACTIVE) begin
        bank_reg <= wr_addr[22:21];
        col_reg  <= wr_addr[7:0];
        len_reg  <= (wr_burst_len == 10'd0) ? 10'd1 : wr_burst_len;
      end
      wr_cmd        <= CMD_NOP;
      wr_ba         <= 2'd0;
      wr_sdram_addr <= 13'd0;
      wr_sdram_en   <= 1'b0;
      wr_ack        <= 1'b0;
      wr_end        <= 1'b0;
      case (state_next)
        S_ACTIVE: begin
          wr_cmd        <= CMD_ACTIVE;
          wr_ba         <= wr_addr[22:21];
          wr_sdram_addr <= wr_addr[20:8];
        end
        S_WRITE: begin
          wr_cmd        <= CMD_WRITE;
          wr_ba         <= bank_reg;
          wr_sdram_addr <= {5'b0, col_reg};
          wr_sdram_en   <= 1'b1;
          wr_ack        <= 1'b1;
        end
        S_DATA: begin
          wr_sdram_en <= 1'b1;
          wr_ack      <= 1'b1;
        end
        S_STOP: wr_cmd <= CMD_BSTOP;
        S_PRECH: begin
          wr_cmd        <= CMD_PRECHARGE;
          wr_ba         <= bank_reg;
          wr_sdram_addr <= 13'h0400;
        end
        S_END:   wr_end <= 1'b1;
        default: ;
      endcase
    end
  end

  // Show-ahead FIFO: the acked word is already on wr_data
  assign wr_sdram_data = wr_sdram_en ? wr_data : 16'h0000;

endmodule

// File: doc/sdram_burst_write.md
# sdram_burst_write

Drives one full-page SDRAM write burst on behalf of the SDRAM controller's arbiter. On a grant it opens the row, streams `wr_burst_len` words out of the write FIFO and onto the SDRAM DQ bus, terminates the burst, precharges all banks, and then reports completion. Its `wr_ack` output is the SDRAM write acknowledge: it pops the write FIFO, and its falling edge advances the FIFO controller's write address. It sits between the SDRAM arbiter (command/address/DQ mux) and the FIFO control stage.

## Interface
Parameters:
- TRCD_CLK, 2: ACTIVE-to-WRITE delay in clocks (≥1).
- TRP_CLK, 2: PRECHARGE-to-next-command delay in clocks (≥1).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- init_end  in  1  SDRAM initialisation complete.
- wr_en  in  1  arbiter grant; sampled only in IDLE.
- wr_addr  in  23  burst start address: bank [22:21], row [20:8], column [7:0].
- wr_burst_len  in  10  words per burst.
- wr_data  in  16  write FIFO show-ahead output.
- wr_ack  out  1  high on each cycle a word is consumed; this is the FIFO rdreq.
- wr_end  out  1  one-cycle pulse when the burst is complete.
- wr_cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- wr_ba  out  2  bank address.
- wr_sdram_addr  out  13  SDRAM A[12:0].
- wr_sdram_en  out  1  DQ output enable.
- wr_sdram_data  out  16  DQ write data.

## Operation
- Command encodings:
  - NOP = 4'b0111
  - ACTIVE = 4'b0011
  - WRITE = 4'b0100
  - BURST_STOP = 4'b0110
  - PRECHARGE = 4'b0010
- The SDRAM mode register is programmed for full-page burst. The burst is cut with BURST_STOP.
- State machine: IDLE → ACTIVE → TRCD → WRITE → DATA → STOP → PRECH → TRP → END → IDLE.
- IDLE → ACTIVE when `wr_en & init_end`.
  - On that transition the block latches `wr_addr` and `wr_burst_len` into internal registers.
  - Any later change on these inputs is ignored until the block returns to IDLE.
- Latched length 0 is treated as 1.
- ACTIVE: drive the ACTIVE command with `wr_ba` = bank and `wr_sdram_addr` = row.
- TRCD: drive NOP for TRCD_CLK−1 cycles. If TRCD_CLK = 1, this state is skipped.
- WRITE (1 cycle): drive the WRITE command with `wr_sdram_addr` = {5'b0, column}. This cycle carries data beat 0.
- DATA: carries beats 1..N−1 with NOP commands. Beats are counted by a 10-bit counter.
- STOP: drive BURST_STOP for 1 cycle.
- PRECH: drive PRECHARGE for 1 cycle with `wr_sdram_addr[10]` = 1 (all banks).
- TRP: drive NOP for TRP_CLK−1 cycles.
- END: drive `wr_end` = 1 and NOP for 1 cycle, then return to IDLE.
- `wr_ack` = `wr_sdram_en` = 1 exactly on the N beat cycles (WRITE plus DATA).
- `wr_sdram_data` = `wr_data` while `wr_sdram_en` is high, otherwise 16'h0000. Because the FIFO is show-ahead, the word is valid in the same cycle it is acked.
- Bursts that cross the column-255 boundary wrap inside the row. The block does not split them; preventing this is the upstream stage's job.
- An empty FIFO is not checked. The upstream stage requests a burst only when enough data is present.
- `init_end` falling mid-burst has no effect; the burst completes.

## Timing
- Reset values: state = IDLE, `wr_cmd` = NOP, `wr_ba` = 0, `wr_sdram_addr` = 0, `wr_ack` = 0, `wr_end` = 0, `wr_sdram_en` = 0, `wr_sdram_data` = 0, counters = 0.
- All outputs are registered. The only exception is `wr_sdram_data`, which is the gated `wr_data` passthrough.
- Cycle numbering: cycle 0 is the cycle in which `wr_en` is sampled high in IDLE.

| Event | Cycle |
|---|---|
| ACTIVE | 1 |
| WRITE | 1+TRCD_CLK |
| Last beat | TRCD_CLK+N |
| BURST_STOP | TRCD_CLK+N+1 |
| PRECHARGE | TRCD_CLK+N+2 |
| `wr_end` | TRCD_CLK+N+TRP_CLK+2 |
| Back in IDLE (accepts `wr_en` again) | TRCD_CLK+N+TRP_CLK+3 |

- Total occupancy = N + TRCD_CLK + TRP_CLK + 3 cycles.
- Reset asserted mid-burst: all outputs return immediately to their reset values. `wr_ack` drops without a completed burst.

## Test plan
- Nominal burst: TRCD = TRP = 2, N = 4, `wr_addr` = 23'h20_1234, i.e. bank 1, row 0x012, col 0x34.
  - ACTIVE at cycle 1 with `wr_ba` = 1 and A = 0x012.
  - WRITE at cycle 3 with A = 0x034.
  - `wr_ack` high on cycles 3–6, with the DQ bus carrying the FIFO words in order.
  - BURST_STOP at cycle 7, PRECHARGE at cycle 8 with A[10] = 1.
  - `wr_end` at cycle 10.
- `init_end` = 0 with `wr_en` = 1 for 20 cycles: the block stays in IDLE, `wr_cmd` stays NOP, and `wr_ack` stays 0.
- `wr_burst_len` = 0: exactly 1 ack cycle (cycle 3), and `wr_end` at cycle 7.
- Back-to-back grants: hold `wr_en` high continuously with N = 8. The second ACTIVE occurs 2 cycles after the first `wr_end`. There are 8 acks per burst, and `wr_addr`/`wr_burst_len` changes mid-burst are ignored.
- Reset mid-burst: assert `sys_rst_n` = 0 at the 3rd beat of N = 16. Outputs go to reset values asynchronously. After release, the next `wr_en` starts a clean burst from ACTIVE.
- Maximum length: N = 1023 with TRCD = TRP = 3. Exactly 1023 ack cycles, and `wr_end` at cycle 1031.
